// File: rtl/i2s_tx_fifo.sv
// Stereo sample FIFO feeding the I2S transmitter: one {left,right} pair popped per frame,
// with level/watermark reporting and sticky underrun/overflow status for the register block.
module i2s_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          wr_valid,
    input  logic [31:0]   wr_left,
    input  logic [31:0]   wr_right,
    output logic          wr_ready,
    input  logic          data_rqst,
    output logic [31:0]   data_left,
    output logic [31:0]   data_right,
    output logic [AW:0]   level,
    input  logic [AW:0]   thresh,
    output logic          low_irq,
    output logic          underrun,
    output logic          overflow,
    input  logic          status_clr
);

    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [63:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [31:0]   data_left_q, data_left_d;
    logic [31:0]   data_right_q, data_right_d;
    logic          underrun_q, underrun_d;
    logic          overflow_q, overflow_d;
    logic          full, empty, push, pop;
    logic [63:0]   head;

    // Full/empty come from the pre-operation level, so a same-cycle pop never rescues a write.
    assign full  = (level_q == FULL_LEVEL);
    assign empty = (level_q == '0);
    assign push  = wr_valid && !full && !flush;
    assign pop   = data_rqst && !empty && !flush;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        data_left_d  = data_left_q;
        data_right_d = data_right_q;
        if (flush) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            level_d      = '0;
            data_left_d  = '0;
            data_right_d = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                data_left_d  = head[63:32];
                data_right_d = head[31:0];
            end else if (data_rqst) begin
                data_left_d  = '0;
                data_right_d = '0;
            end
            case ({push, pop})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // A set condition in the same cycle as status_clr wins; flush suppresses both sets.
    always_comb begin
        underrun_d = underrun_q && !status_clr;
        overflow_d = overflow_q && !status_clr;
        if (!flush && data_rqst && empty) begin
            underrun_d = 1'b1;
        end
        if (!flush && wr_valid && full) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            data_left_q  <= '0;
            data_right_q <= '0;
            underrun_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            data_left_q  <= data_left_d;
            data_right_q <= data_right_d;
            underrun_q   <= underrun_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= {wr_left, wr_right};
        end
    end

    assign wr_ready   = !full;
    assign low_irq    = (level_q <= thresh);
    assign level      = level_q;
    assign data_left  = data_left_q;
    assign data_right = data_right_q;
    assign underrun   = underrun_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/i2s_tx_fifo.md
# i2s_tx_fifo

Stereo sample buffer sitting directly upstream of the I2S master transmitter. It accepts left/right 32-bit sample pairs from the register/bus side and hands one pair to the transmitter per frame on its `data_rqst` pulse. It provides level reporting, a low-watermark interrupt, and sticky underrun/overflow status for the APB register block.

## Interface
Parameters:
- `DEPTH`, 8, number of stereo pairs stored; power of two, ≥2
- `AW`, $clog2(DEPTH), derived; pointer width

Ports:
- `clk` in 1: system clock, same domain as the transmitter
- `rst` in 1: reset, synchronous, active-high
- `flush` in 1: one-cycle pulse; empties the FIFO
- `wr_valid` in 1: write-side sample pair valid
- `wr_left` in 32: left sample
- `wr_right` in 32: right sample
- `wr_ready` out 1: FIFO not full
- `data_rqst` in 1: pop request from the transmitter; one-cycle pulse per frame
- `data_left` out 32: registered left sample to the transmitter
- `data_right` out 32: registered right sample to the transmitter
- `level` out AW+1: number of stored pairs, 0..DEPTH
- `thresh` in AW+1: low-watermark threshold
- `low_irq` out 1: level ≤ thresh
- `underrun` out 1: sticky; a pop hit an empty FIFO
- `overflow` out 1: sticky; a write hit a full FIFO
- `status_clr` in 1: one-cycle pulse; clears `underrun` and `overflow`

## Operation
- Storage is DEPTH × 64-bit entries (`{left,right}`). Write and read pointers are AW bits wide and wrap modulo DEPTH. Full/empty are derived from `level` (0 = empty, DEPTH = full).
- Push occurs when `wr_valid && !full`. The entry is written at the write pointer, and the pointer advances.
- Write when full (`wr_valid && full`): the data is dropped, nothing changes, and `overflow` is set. A pop in the same cycle does not rescue the write, because `wr_ready` is evaluated on the pre-pop state.
- Pop occurs when `data_rqst && !empty`. `data_left`/`data_right` are loaded from the head entry, and the read pointer advances.
- Pop when empty: `data_left`/`data_right` are loaded with 0 (silence), pointers are unchanged, and `underrun` is set. There is no write-to-read bypass: a simultaneous push into an empty FIFO is stored and counts as an underrun.
- Push and pop in the same cycle (neither blocked): `level` is unchanged.
- `level` update: +1 on push only, −1 on pop only.
- `flush`: pointers and `level` go to 0 and `data_left`/`data_right` go to 0. It has priority over a push or pop in the same cycle; that push/pop is ignored and no status flag is set by it. Sticky flags are not cleared by flush.
- `status_clr`: clears both sticky flags. If a set condition occurs in the same cycle, the set wins.
- `low_irq` = `level <= thresh`, combinational from the registered `level`. `thresh` ≥ DEPTH holds it permanently high.
- `rst` (sync, high): pointers, `level`, `data_left`, `data_right`, `underrun`, `overflow` all go to 0. After reset, `wr_ready`=1 and `low_irq`=1. Storage RAM is not cleared. Reset during operation discards all content on that edge.

## Timing
- `wr_ready` = `!full`, combinational from registered `level`.
- Pop latency is 1 cycle. On the clock edge where `data_rqst`=1 is sampled, the output registers update, so they are valid in the cycle after `data_rqst`. The transmitter loads its shift register on the following edge.
- Outputs hold their value between requests.
- A push into an empty FIFO is visible to a pop in the next cycle.
- Full throughput: one push and one pop per cycle simultaneously.
- `level`, `wr_ready` and `low_irq` reflect an operation one cycle after its edge.
- Sticky flags assert in the cycle after the offending event.

## Test plan
- Reset: assert `rst` for 2 cycles → `level`=0, `wr_ready`=1, `low_irq`=1 (thresh=0), `data_left`=`data_right`=0, `underrun`=`overflow`=0.
- Fill/overflow, DEPTH=8: write pairs (L=i, R=0x100+i) for i=0..8 → after 8 writes `wr_ready`=0 and `level`=8; the 9th write is dropped and `overflow`=1. Eight `data_rqst` pulses spaced 8 cycles apart return L=0..7 and R=0x100..0x107 in order, one cycle after each request. Final `level`=0.
- Underrun: with the FIFO empty, pulse `data_rqst` → outputs 0 next cycle and `underrun`=1. `status_clr` → `underrun`=0. `status_clr` coincident with another empty pop → `underrun` stays 1.
- Simultaneous operations: `level`=3, `wr_valid` and `data_rqst` in the same cycle → `level` stays 3 and the head pair is output. Full FIFO with `wr_valid`+`data_rqst` together → pop happens, write is dropped, `overflow`=1, `level`=7.
- Flush: `level`=5, `flush` coincident with `wr_valid` → `level`=0, outputs 0, `overflow` and `underrun` unchanged. A following write then pop returns that new pair.
- Watermark and wrap: `thresh`=2, stream 40 pairs through with interleaved pops → `low_irq` toggles exactly as `level` crosses 2↔3. Data order is preserved across multiple pointer wraps.
